wheel_speed_loop: RTL
=====================

Name: wheel_speed_loop

Overview:
Parametrised closed-loop speed controller for one robot wheel, the successor to the current fixed-width wheel controller. It integrates signed x4 quadrature decoding, a self-timed measurement window, a signed PI controller with runtime gains and anti-windup, and a glitch-free PWM generator with a 2-bit H-bridge direction/brake output. Setpoint and feedback are signed encoder counts per window, so no rad/s or rpm conversion happens inside the loop. One instance is placed per wheel under the robot top level.

Parameters:
CNT_W, 16, signed width of the count, setpoint and measurement buses.
WIN_CYCLES, 8388608, measurement window length in clocks (167.77 ms at 50 MHz); must be ≥ 8.
PWM_W, 8, PWM/duty resolution in bits.
GAIN_W, 8, unsigned gain width.
GAIN_FRAC, 4, fractional bits of the gains (default gains are Q4.4).
ACC_W, 24, signed integrator width.

Ports:
WHEEL_SPEED_LOOP_CLOCK  in  1  system clock.
WHEEL_SPEED_LOOP_RESET_InLow  in  1  asynchronous, active-low reset.
WHEEL_SPEED_LOOP_ENABLE_In  in  1  loop enable.
WHEEL_SPEED_LOOP_SETPOINT_InBus  in  CNT_W  signed target, counts/window.
WHEEL_SPEED_LOOP_KP_InBus  in  GAIN_W  unsigned proportional gain.
WHEEL_SPEED_LOOP_KI_InBus  in  GAIN_W  unsigned integral gain.
WHEEL_SPEED_LOOP_ENCA_In  in  1  encoder phase A (asynchronous).
WHEEL_SPEED_LOOP_ENCB_In  in  1  encoder phase B (asynchronous).
WHEEL_SPEED_LOOP_PWMCE_In  in  1  PWM counter clock-enable strobe.
WHEEL_SPEED_LOOP_CLRQERR_In  in  1  clears the sticky quadrature error flag.
WHEEL_SPEED_LOOP_PWM_Out  out  1  motor PWM.
WHEEL_SPEED_LOOP_DIR_OutBus  out  2  10 = forward, 01 = reverse, 00 = coast, 11 = brake.
WHEEL_SPEED_LOOP_DUTY_OutBus  out  PWM_W  commanded duty magnitude.
WHEEL_SPEED_LOOP_MEAS_OutBus  out  CNT_W  signed counts in the last window.
WHEEL_SPEED_LOOP_SAMPLE_Out  out  1  one-cycle pulse when MEAS updates.
WHEEL_SPEED_LOOP_QERR_Out  out  1  sticky illegal-transition flag.

Behaviour:
- Reset: every register and output is 0 (DIR = 00, PWM = 0). Reset mid-window discards the partial count. Reset is asynchronous assert; deassertion is synchronous to the clock.
- Encoder input: ENCA and ENCB pass through a 2-FF synchroniser plus one history register.
- Quadrature decode is x4. The sequence 00→01→11→10→00 counts +1; the reverse sequence counts -1. No change counts 0.
- A double-bit change is illegal: the count is unchanged and QERR is set. QERR clears only on CLRQERR; if CLRQERR and a new error occur in the same cycle, QERR stays set.
- The window accumulator saturates at ±(2^(CNT_W-1)-1).
- Window: a counter runs 0..WIN_CYCLES-1. At the terminal cycle's edge, MEAS is loaded with the accumulator value including that cycle's step, and SAMPLE goes high for one cycle. The accumulator restarts at 0, so no edge is lost or double-counted.
- PI pipeline:
  - Edge S+1, where S is the SAMPLE edge: err = SETPOINT - MEAS, computed in CNT_W+1 bits with no overflow.
  - Edge S+2: p = err*KP; cand = integ + err*KI, saturated to ACC_W; u = (p + cand) >>> GAIN_FRAC, arithmetic shift.
  - u saturates to ±(2^PWM_W-1).
  - Anti-windup: integ takes cand unless u saturated and sign(err) equals the saturation sign; in that case integ holds.
  - DUTY = |u_sat| and DIR = 10 if u > 0, 01 if u < 0, 11 if u = 0. Both update at edge S+2, giving a latency of 2 clocks from SAMPLE.
- SETPOINT = 0 while enabled: at the next SAMPLE pipeline, integ clears, DUTY = 0 and DIR = 11 (brake).
- ENABLE low: integ clears and DUTY and DIR go to 0 at the next edge, with no waiting for SAMPLE. Measurement continues. When ENABLE rises, control resumes at the next SAMPLE.
- PWM:
  - A PWM_W-bit counter increments on each clock where PWMCE = 1 and wraps 2^PWM_W-1 → 0.
  - An active-duty register reloads from DUTY only on wrap, so there are no glitches mid-period. Exception: ENABLE low forces active duty to 0 immediately.
  - PWM_Out = (counter < active duty), registered. DUTY = 2^PWM_W-1 gives one low slot per period.
- Gains are sampled at edge S+2; changing them at other times has no effect until then.

Test Plan:
- Reset: assert RESET_InLow mid-run with DUTY = 200 -> all outputs 0 asynchronously; after release, the first SAMPLE occurs exactly WIN_CYCLES clocks later.
- Counting: WIN_CYCLES = 1000, 40 forward transitions spaced 20 clocks -> MEAS = 40 with one-cycle SAMPLE; 40 reverse transitions -> MEAS = -40 (0xFFD8). A transition on the terminal cycle lands in the closing window only.
- Illegal edge: inject 00→11 -> MEAS unchanged by it, QERR = 1 held until CLRQERR pulse, then 0.
- Proportional: KP = 0x10, KI = 0, SETPOINT = 100, no encoder -> DUTY = 100, DIR = 10, two clocks after SAMPLE. SETPOINT = -300 -> DUTY = 255, DIR = 01. SETPOINT = 0 -> DUTY = 0, DIR = 11.
- Anti-windup: KP = 0, KI = 0x10, SETPOINT = 200 -> sample 1 DUTY = 200; sample 2 DUTY = 255 with integ held at 3200. SETPOINT = -10 -> next DUTY = 190, DIR = 10.
- PWM/enable: DUTY = 64, PWMCE = 1 every clock -> 64 high clocks per 256. DUTY changed to 128 mid-period -> takes effect from the next wrap. ENABLE dropped -> PWM_Out = 0, DIR = 00 within 1 clock.

Source files
------------

// File: rtl/wheel_speed_loop.sv
// Closed-loop speed controller for one wheel: x4 quadrature count over a fixed window,
// PI control with anti-windup, and a period-synchronous PWM with H-bridge direction.
module wheel_speed_loop #(
    parameter int CNT_W      = 16,
    parameter int WIN_CYCLES = 8388608,
    parameter int PWM_W      = 8,
    parameter int GAIN_W     = 8,
    parameter int GAIN_FRAC  = 4,
    parameter int ACC_W      = 24
) (
    input  logic                    WHEEL_SPEED_LOOP_CLOCK,
    input  logic                    WHEEL_SPEED_LOOP_RESET_InLow,
    input  logic                    WHEEL_SPEED_LOOP_ENABLE_In,
    input  logic signed [CNT_W-1:0] WHEEL_SPEED_LOOP_SETPOINT_InBus,
    input  logic [GAIN_W-1:0]       WHEEL_SPEED_LOOP_KP_InBus,
    input  logic [GAIN_W-1:0]       WHEEL_SPEED_LOOP_KI_InBus,
    input  logic                    WHEEL_SPEED_LOOP_ENCA_In,
    input  logic                    WHEEL_SPEED_LOOP_ENCB_In,
    input  logic                    WHEEL_SPEED_LOOP_PWMCE_In,
    input  logic                    WHEEL_SPEED_LOOP_CLRQERR_In,
    output logic                    WHEEL_SPEED_LOOP_PWM_Out,
    output logic [1:0]              WHEEL_SPEED_LOOP_DIR_OutBus,
    output logic [PWM_W-1:0]        WHEEL_SPEED_LOOP_DUTY_OutBus,
    output logic signed [CNT_W-1:0] WHEEL_SPEED_LOOP_MEAS_OutBus,
    output logic                    WHEEL_SPEED_LOOP_SAMPLE_Out,
    output logic                    WHEEL_SPEED_LOOP_QERR_Out
);

    localparam int WIN_W  = (WIN_CYCLES > 1) ? $clog2(WIN_CYCLES) : 1;
    localparam int ERR_W  = CNT_W + 1;
    localparam int PROD_W = ERR_W + GAIN_W + 1;
    localparam int SUM_W  = ((PROD_W > ACC_W) ? PROD_W : ACC_W) + 2;

    localparam logic signed [CNT_W-1:0] CNT_MAX = $signed({1'b0, {(CNT_W-1){1'b1}}});
    localparam logic signed [CNT_W-1:0] CNT_MIN = $signed({1'b1, {(CNT_W-2){1'b0}}, 1'b1});
    localparam logic signed [SUM_W-1:0] ACC_MAX = $signed({{(SUM_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}});
    localparam logic signed [SUM_W-1:0] ACC_MIN = $signed({{(SUM_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}});
    localparam logic signed [SUM_W-1:0] U_MAX   = $signed({{(SUM_W-PWM_W){1'b0}}, {PWM_W{1'b1}}});
    localparam logic signed [SUM_W-1:0] U_MIN   = -U_MAX;

    logic clk;
    logic rst_n;
    logic enable;

    assign clk    = WHEEL_SPEED_LOOP_CLOCK;
    assign rst_n  = WHEEL_SPEED_LOOP_RESET_InLow;
    assign enable = WHEEL_SPEED_LOOP_ENABLE_In;

    logic [1:0]              enc_meta_reg, enc_sync_reg, enc_hist_reg;
    logic [1:0]              pos_cur, pos_prev, pos_diff;
    logic                    step_up, step_dn, step_bad;
    logic signed [CNT_W-1:0] acc_reg, acc_next, meas_reg;
    logic [WIN_W-1:0]        win_cnt_reg;
    logic                    win_last, sample_reg, qerr_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enc_meta_reg <= '0;
            enc_sync_reg <= '0;
            enc_hist_reg <= '0;
        end else begin
            enc_meta_reg <= {WHEEL_SPEED_LOOP_ENCA_In, WHEEL_SPEED_LOOP_ENCB_In};
            enc_sync_reg <= enc_meta_reg;
            enc_hist_reg <= enc_sync_reg;
        end
    end

    // Gray state -> binary position, so the sign of a legal move is a modulo-4 difference.
    assign pos_cur  = {enc_sync_reg[1], enc_sync_reg[1] ^ enc_sync_reg[0]};
    assign pos_prev = {enc_hist_reg[1], enc_hist_reg[1] ^ enc_hist_reg[0]};
    assign pos_diff = pos_cur - pos_prev;
    assign step_up  = (pos_diff == 2'd1);
    assign step_dn  = (pos_diff == 2'd3);
    assign step_bad = (pos_diff == 2'd2);

    always_comb begin
        acc_next = acc_reg;
        if (step_up && (acc_reg != CNT_MAX))
            acc_next = acc_reg + CNT_W'(1);
        else if (step_dn && (acc_reg != CNT_MIN))
            acc_next = acc_reg - CNT_W'(1);
    end

    assign win_last = (win_cnt_reg == WIN_W'(WIN_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt_reg <= '0;
            acc_reg     <= '0;
            meas_reg    <= '0;
            sample_reg  <= 1'b0;
        end else if (win_last) begin
            win_cnt_reg <= '0;
            acc_reg     <= '0;
            meas_reg    <= acc_next;
            sample_reg  <= 1'b1;
        end else begin
            win_cnt_reg <= win_cnt_reg + WIN_W'(1);
            acc_reg     <= acc_next;
            sample_reg  <= 1'b0;
        end
    end

    // A new error wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            qerr_reg <= 1'b0;
        else if (step_bad)
            qerr_reg <= 1'b1;
        else if (WHEEL_SPEED_LOOP_CLRQERR_In)
            qerr_reg <= 1'b0;
    end

    logic signed [ERR_W-1:0]  err_reg;
    logic                     stage2_reg, sp_zero_reg;
    logic signed [ACC_W-1:0]  integ_reg, cand;
    logic signed [PROD_W-1:0] p_full, i_full;
    logic signed [SUM_W-1:0]  i_sum, u_full;
    logic                     sat_hi, sat_lo, err_pos, err_neg, integ_hold;
    logic [PWM_W-1:0]         duty_val, duty_reg;
    logic [1:0]               dir_val, dir_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_reg     <= '0;
            sp_zero_reg <= 1'b0;
            stage2_reg  <= 1'b0;
        end else begin
            stage2_reg <= sample_reg & enable;
            if (sample_reg) begin
                err_reg     <= ERR_W'(WHEEL_SPEED_LOOP_SETPOINT_InBus) - ERR_W'(meas_reg);
                sp_zero_reg <= (WHEEL_SPEED_LOOP_SETPOINT_InBus == '0);
            end
        end
    end

    assign p_full = PROD_W'(err_reg) * PROD_W'($signed({1'b0, WHEEL_SPEED_LOOP_KP_InBus}));
    assign i_full = PROD_W'(err_reg) * PROD_W'($signed({1'b0, WHEEL_SPEED_LOOP_KI_InBus}));
    assign i_sum  = SUM_W'(integ_reg) + SUM_W'(i_full);

    always_comb begin
        cand = ACC_W'(i_sum);
        if (i_sum > ACC_MAX)
            cand = ACC_W'(ACC_MAX);
        else if (i_sum < ACC_MIN)
            cand = ACC_W'(ACC_MIN);
    end

    assign u_full     = (SUM_W'(p_full) + SUM_W'(cand)) >>> GAIN_FRAC;
    assign sat_hi     = (u_full > U_MAX);
    assign sat_lo     = (u_full < U_MIN);
    assign err_neg    = err_reg[ERR_W-1];
    assign err_pos    = !err_neg && (err_reg != '0);
    // Freeze the integrator only while it would push further into the active limit.
    assign integ_hold = (sat_hi && err_pos) || (sat_lo && err_neg);

    always_comb begin
        duty_val = '0;
        dir_val  = 2'b11;
        if (sat_hi || sat_lo)
            duty_val = '1;
        else if (u_full[SUM_W-1])
            duty_val = PWM_W'(-u_full);
        else
            duty_val = PWM_W'(u_full);
        if (u_full[SUM_W-1])
            dir_val = 2'b01;
        else if (u_full != '0)
            dir_val = 2'b10;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            integ_reg <= '0;
            duty_reg  <= '0;
            dir_reg   <= 2'b00;
        end else if (!enable) begin
            integ_reg <= '0;
            duty_reg  <= '0;
            dir_reg   <= 2'b00;
        end else if (stage2_reg) begin
            if (sp_zero_reg) begin
                integ_reg <= '0;
                duty_reg  <= '0;
                dir_reg   <= 2'b11;
            end else begin
                if (!integ_hold)
                    integ_reg <= cand;
                duty_reg <= duty_val;
                dir_reg  <= dir_val;
            end
        end
    end

    logic [PWM_W-1:0] pwm_cnt_reg, active_duty_reg;
    logic             pwm_wrap, pwm_reg;

    assign pwm_wrap = WHEEL_SPEED_LOOP_PWMCE_In && (pwm_cnt_reg == '1);

    // Active duty only reloads on the period wrap so a period is never cut short or stretched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt_reg     <= '0;
            active_duty_reg <= '0;
            pwm_reg         <= 1'b0;
        end else begin
            if (WHEEL_SPEED_LOOP_PWMCE_In)
                pwm_cnt_reg <= pwm_cnt_reg + PWM_W'(1);
            if (!enable)
                active_duty_reg <= '0;
            else if (pwm_wrap)
                active_duty_reg <= duty_reg;
            pwm_reg <= enable && (pwm_cnt_reg < active_duty_reg);
        end
    end

    assign WHEEL_SPEED_LOOP_PWM_Out     = pwm_reg;
    assign WHEEL_SPEED_LOOP_DIR_OutBus  = dir_reg;
    assign WHEEL_SPEED_LOOP_DUTY_OutBus = duty_reg;
    assign WHEEL_SPEED_LOOP_MEAS_OutBus = meas_reg;
    assign WHEEL_SPEED_LOOP_SAMPLE_Out  = sample_reg;
    assign WHEEL_SPEED_LOOP_QERR_Out    = qerr_reg;

endmodule
